// File: rtl/spi_cfg_regs_pkg.sv
// Shared definitions for the SPI configuration register slave: FSM states,
// command byte layout and the byte map of the synth parameters held in cfg.
package cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CMD    = 2'd1,
    ST_DATA   = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  // Command byte layout: W flag on top, start address below it
  localparam int CMD_W_BIT = 7;
  localparam int ADDR_W    = 7;

  // Writing this address fires a trigger pulse instead of storing data
  localparam logic [ADDR_W-1:0] DEFAULT_TRIG_ADDR = 7'h7F;

  // Synth field byte offsets inside cfg (multi-byte fields are little-endian)
  localparam int ADSR_A          = 0;
  localparam int ADSR_D          = 1;
  localparam int ADSR_S          = 2;
  localparam int ADSR_R          = 3;
  localparam int OSC_COUNT       = 4;
  localparam int OSC_COUNT_BYTES = 4;
  localparam int FILTER_A        = 8;
  localparam int FILTER_A_BYTES  = 2;
  localparam int FILTER_B        = 10;
  localparam int FILTER_B_BYTES  = 2;

  // Address auto-increment; the 7-bit address space wraps 127 -> 0
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
    return addr + 7'd1;
  endfunction

endpackage

// File: rtl/spi_cfg_regs_sync_edge.sv
// Clock-domain crossing helpers for the SPI pins: a plain multi-flop
// synchroniser, and a synchroniser with single-cycle rise/fall pulses.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  // Move the asynchronous input one stage deeper each clock
  always_comb begin
    chain_d    = chain_q;
    chain_d[0] = d_i;
    for (int i = 1; i < STAGES; i++) begin
      chain_d[i] = chain_q[i-1];
    end
  end

  // Synchroniser flops, reset to the pin's idle level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= {STAGES{RST_VAL}};
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic level_s;
  logic prev_q;
  logic prev_d;

  spi_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (RST_VAL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (d_i),
    .q_o (level_s)
  );

  // Previous synchronised level, used to spot transitions
  always_comb begin
    prev_d = level_s;
  end

  // Delayed copy of the synchronised level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= RST_VAL;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise_o = level_s & ~prev_q;
  assign fall_o = ~level_s & prev_q;

endmodule

// File: rtl/spi_cfg_regs.sv
// SPI mode-0 configuration slave: addressed byte register file with burst
// writes into shadow registers, atomic commit on nss rise, readback on miso,
// a trigger address and an audio mute during write transactions.
module spi_cfg_regs
  import cfg_pkg::*;
#(
  parameter int                NUM_BYTES   = 12,
  parameter logic [ADDR_W-1:0] TRIG_ADDR   = DEFAULT_TRIG_ADDR,
  parameter int                SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sck,
  input  logic                   mosi,
  input  logic                   nss,
  output logic                   miso,
  output logic                   miso_oe,
  output logic [NUM_BYTES*8-1:0] cfg,
  output logic                   cfg_valid,
  output logic                   mute,
  output logic                   trig
);

  localparam int CFG_W = NUM_BYTES * 8;

  // Byte at addr from a register image; unimplemented addresses read as zero
  function automatic logic [7:0] reg_byte(input logic [CFG_W-1:0] regs,
                                          input logic [ADDR_W-1:0] addr);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (addr == ADDR_W'(i)) begin
        b = regs[8*i +: 8];
      end
    end
    return b;
  endfunction

  logic sck_rise_s, sck_fall_s;
  logic nss_rise_s, nss_fall_s;
  logic mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sck),
    .rise_o (sck_rise_s),
    .fall_o (sck_fall_s)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_nss_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (nss),
    .rise_o (nss_rise_s),
    .fall_o (nss_fall_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk (clk),
    .rst (rst),
    .d_i (mosi),
    .q_o (mosi_s)
  );

  state_e              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shreg_q, shreg_d;
  logic                is_write_q, is_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                dirty_q, dirty_d;
  logic                trig_pending_q, trig_pending_d;
  logic [CFG_W-1:0]    shadow_q, shadow_d;
  logic [CFG_W-1:0]    cfg_q, cfg_d;
  logic                cfg_valid_q, cfg_valid_d;
  logic                trig_q, trig_d;
  logic                mute_q, mute_d;
  logic                miso_oe_q, miso_oe_d;
  logic [7:0]          miso_sr_q, miso_sr_d;
  logic                miso_q, miso_d;
  logic [7:0]          byte_s;
  logic [7:0]          rd_byte_s;

  // Byte as it stands once the current mosi bit is shifted in
  assign byte_s = {shreg_q[6:0], mosi_s};

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: frame start, command completion, frame end
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (nss_fall_s) begin
          state_d = ST_CMD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (nss_rise_s) begin
          state_d = ST_IDLE;
        end else if (sck_rise_s && (bit_cnt_q == 3'd7)) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_DATA: begin
        if (nss_rise_s) begin
          state_d = (is_write_q && dirty_q) ? ST_COMMIT : ST_IDLE;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs for each FSM state
  always_comb begin
    bit_cnt_d      = bit_cnt_q;
    shreg_d        = shreg_q;
    is_write_d     = is_write_q;
    addr_d         = addr_q;
    dirty_d        = dirty_q;
    trig_pending_d = trig_pending_q;
    shadow_d       = shadow_q;
    cfg_d          = cfg_q;
    cfg_valid_d    = 1'b0;
    trig_d         = 1'b0;
    mute_d         = mute_q;
    miso_oe_d      = miso_oe_q;
    miso_sr_d      = miso_sr_q;
    miso_d         = miso_q;
    rd_byte_s      = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (nss_fall_s) begin
          // Start every frame from the committed image
          shadow_d       = cfg_q;
          bit_cnt_d      = 3'd0;
          shreg_d        = 8'h00;
          is_write_d     = 1'b0;
          dirty_d        = 1'b0;
          trig_pending_d = 1'b0;
          addr_d         = {ADDR_W{1'b0}};
          miso_sr_d      = 8'h00;
          miso_d         = 1'b0;
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end

      ST_CMD: begin
        if (nss_rise_s) begin
          mute_d    = 1'b0;
          miso_oe_d = 1'b0;
          miso_d    = 1'b0;
        end else if (sck_rise_s) begin
          shreg_d   = byte_s;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            is_write_d = byte_s[CMD_W_BIT];
            addr_d     = byte_s[ADDR_W-1:0];
            if (byte_s[CMD_W_BIT]) begin
              mute_d = 1'b1;
            end else begin
              // Read: first data byte is on miso before the next sck rise
              rd_byte_s = reg_byte(shadow_q, byte_s[ADDR_W-1:0]);
              miso_oe_d = 1'b1;
              miso_sr_d = rd_byte_s;
              miso_d    = rd_byte_s[7];
            end
          end else begin
            addr_d = addr_q;
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end

      ST_DATA: begin
        if (nss_rise_s) begin
          // Any partial trailing byte in shreg is simply dropped
          mute_d    = 1'b0;
          miso_oe_d = 1'b0;
          miso_d    = 1'b0;
        end else if (sck_rise_s) begin
          shreg_d   = byte_s;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            addr_d = next_addr(addr_q);
            if (is_write_q) begin
              dirty_d = 1'b1;
              for (int i = 0; i < NUM_BYTES; i++) begin
                if (addr_q == ADDR_W'(i)) begin
                  shadow_d[8*i +: 8] = byte_s;
                end
              end
              if (addr_q == TRIG_ADDR) begin
                trig_pending_d = 1'b1;
              end else begin
                trig_pending_d = trig_pending_q;
              end
            end else begin
              dirty_d = dirty_q;
            end
          end else begin
            addr_d = addr_q;
          end
        end else if (sck_fall_s && !is_write_q) begin
          if (bit_cnt_q == 3'd0) begin
            // Byte boundary: present the byte at the (already advanced) address
            rd_byte_s = reg_byte(shadow_q, addr_q);
            miso_sr_d = rd_byte_s;
            miso_d    = rd_byte_s[7];
          end else begin
            miso_sr_d = {miso_sr_q[6:0], 1'b0};
            miso_d    = miso_sr_q[6];
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end

      ST_COMMIT: begin
        cfg_d          = shadow_q;
        cfg_valid_d    = 1'b1;
        trig_d         = trig_pending_q;
        dirty_d        = 1'b0;
        trig_pending_d = 1'b0;
        is_write_d     = 1'b0;
        mute_d         = 1'b0;
      end

      default: begin
        mute_d    = 1'b0;
        miso_oe_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q      <= 3'd0;
      shreg_q        <= 8'h00;
      is_write_q     <= 1'b0;
      addr_q         <= {ADDR_W{1'b0}};
      dirty_q        <= 1'b0;
      trig_pending_q <= 1'b0;
      shadow_q       <= {CFG_W{1'b0}};
      cfg_q          <= {CFG_W{1'b0}};
      cfg_valid_q    <= 1'b0;
      trig_q         <= 1'b0;
      mute_q         <= 1'b0;
      miso_oe_q      <= 1'b0;
      miso_sr_q      <= 8'h00;
      miso_q         <= 1'b0;
    end else begin
      bit_cnt_q      <= bit_cnt_d;
      shreg_q        <= shreg_d;
      is_write_q     <= is_write_d;
      addr_q         <= addr_d;
      dirty_q        <= dirty_d;
      trig_pending_q <= trig_pending_d;
      shadow_q       <= shadow_d;
      cfg_q          <= cfg_d;
      cfg_valid_q    <= cfg_valid_d;
      trig_q         <= trig_d;
      mute_q         <= mute_d;
      miso_oe_q      <= miso_oe_d;
      miso_sr_q      <= miso_sr_d;
      miso_q         <= miso_d;
    end
  end

  assign cfg       = cfg_q;
  assign cfg_valid = cfg_valid_q;
  assign trig      = trig_q;
  assign mute      = mute_q;
  assign miso_oe   = miso_oe_q;
  assign miso      = miso_q;

endmodule

// File: tb/tb_spi_cfg_regs.sv
// Scoreboard bench for spi_cfg_regs: an SPI master drives directed and random
// frames, a register-array model predicts commits and readback bytes, and a
// monitor compares them whenever the DUT commits or shifts out a read byte.
module tb_spi_cfg_regs;

  localparam int NB = 12;

  logic clk, rst, sck, mosi, nss;
  logic miso, miso_oe, cfg_valid, mute, trig;
  logic [NB*8-1:0] cfg;

  spi_cfg_regs #(
    .NUM_BYTES   (NB),
    .TRIG_ADDR   (7'h7F),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sck       (sck),
    .mosi      (mosi),
    .nss       (nss),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .cfg       (cfg),
    .cfg_valid (cfg_valid),
    .mute      (mute),
    .trig      (trig)
  );

  typedef struct {
    logic [NB*8-1:0] cfg;
    logic            trig;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_rd[$];
  logic [7:0] model_regs[NB];
  logic [7:0] tx[16];
  logic       frame_wr;
  int         n_tests;
  int         n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [127:0] got);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0h with nothing expected at %0t", name, got, $time);
  endtask

  function automatic logic [NB*8-1:0] model_cfg();
    logic [NB*8-1:0] v;
    for (int i = 0; i < NB; i++) v[8*i +: 8] = model_regs[i];
    return v;
  endfunction

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
  endtask

  task automatic spi_begin();
    @(posedge clk);
    #2 nss = 1'b0;
    #80;
  endtask

  task automatic spi_end();
    #80 nss = 1'b1;
    #300;
  endtask

  // Predict the frame outcome from the register-map rules, then send it
  task automatic do_frame(input logic [7:0] cmd, input int nbytes, input int extra);
    int   a;
    logic trg;
    exp_t e;
    a   = int'(cmd[6:0]);
    trg = 1'b0;
    if (cmd[7]) begin
      for (int k = 0; k < nbytes; k++) begin
        if (a < NB) model_regs[a] = tx[k];
        if (a == 127) trg = 1'b1;
        a = (a + 1) % 128;
      end
      if (nbytes > 0) begin
        e.cfg  = model_cfg();
        e.trig = trg;
        exp_q.push_back(e);
      end
    end else begin
      for (int k = 0; k < nbytes; k++) begin
        exp_rd.push_back((a < NB) ? model_regs[a] : 8'h00);
        a = (a + 1) % 128;
      end
    end
    frame_wr = cmd[7];
    spi_begin();
    spi_bits(cmd, 8);
    for (int k = 0; k < nbytes; k++) spi_bits(tx[k], 8);
    if (extra > 0) spi_bits(tx[nbytes], extra);
    spi_end();
  endtask

  // Monitor: commits and read bytes are popped from the scoreboard queues
  initial begin : monitor
    logic       prev_sck, prev_nss, prev_valid;
    int         mon_bits;
    logic [7:0] mon_sr;
    logic [7:0] eb;
    exp_t       e;
    prev_sck   = 1'b0;
    prev_nss   = 1'b1;
    prev_valid = 1'b0;
    mon_bits   = 0;
    mon_sr     = 8'h00;
    forever begin
      @(negedge clk);
      if (prev_nss && !nss) begin
        mon_bits = 0;
        mon_sr   = 8'h00;
      end
      if (!prev_sck && sck && !nss) begin
        if (mon_bits >= 8) begin
          check("mute_in_frame", mute, frame_wr);
          check("miso_oe_in_frame", miso_oe, !frame_wr);
          if (!frame_wr) begin
            mon_sr = {mon_sr[6:0], miso};
            if (mon_bits % 8 == 7) begin
              if (exp_rd.size() == 0) fail_now("unexpected_read_byte", mon_sr);
              else begin
                eb = exp_rd.pop_front();
                check("miso_byte", mon_sr, eb);
              end
            end
          end
        end
        mon_bits++;
      end
      if (cfg_valid) begin
        check("cfg_valid_one_clk", prev_valid, 1'b0);
        check("mute_at_commit", mute, 1'b0);
        if (exp_q.size() == 0) fail_now("unexpected_commit", cfg);
        else begin
          e = exp_q.pop_front();
          check("cfg_commit", cfg, e.cfg);
          check("trig_at_commit", trig, e.trig);
        end
      end else if (trig) begin
        fail_now("trig_without_cfg_valid", trig);
      end
      prev_sck   = sck;
      prev_nss   = nss;
      prev_valid = cfg_valid;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_cfg"}, cfg, '0);
    check({tag, "_cfg_valid"}, cfg_valid, 1'b0);
    check({tag, "_mute"}, mute, 1'b0);
    check({tag, "_trig"}, trig, 1'b0);
    check({tag, "_miso"}, miso, 1'b0);
    check({tag, "_miso_oe"}, miso_oe, 1'b0);
  endtask

  initial begin : stimulus
    int wr, sel, addr, nbytes, extra;
    n_tests  = 0;
    n_fail   = 0;
    frame_wr = 1'b0;
    for (int i = 0; i < NB; i++) model_regs[i] = 8'h00;
    rst  = 1'b1;
    nss  = 1'b1;
    sck  = 1'b0;
    mosi = 1'b0;
    #23;
    check_all_zero("reset");
    rst = 1'b0;
    #100;

    // Burst write of the ADSR bytes
    tx[0] = 8'h01; tx[1] = 8'h02; tx[2] = 8'h03; tx[3] = 8'h04;
    do_frame(8'h80, 4, 0);
    check("adsr_word", cfg[31:0], 32'h04030201);

    // Filter B write, then readback with dummy bytes
    tx[0] = 8'hAA; tx[1] = 8'hBB;
    do_frame(8'h8A, 2, 0);
    check("filter_b_word", cfg[95:80], 16'hBBAA);
    tx[0] = 8'h00; tx[1] = 8'h00;
    do_frame(8'h0A, 2, 0);

    // Write past the last register: out-of-range bytes are dropped
    tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33;
    do_frame(8'h8B, 3, 0);
    check("reg11", cfg[95:88], 8'h11);
    do_frame(8'h0C, 1, 0);
    do_frame(8'h0B, 3, 0);

    // Trigger address
    tx[0] = 8'h00;
    do_frame(8'hFF, 1, 0);

    // Partial trailing byte discarded
    tx[0] = 8'h55; tx[1] = 8'hF0;
    do_frame(8'h80, 1, 4);
    check("reg0_after_partial", cfg[7:0], 8'h55);
    check("reg1_after_partial", cfg[15:8], 8'h02);

    // Truncated command byte: no commit
    frame_wr = 1'b1;
    spi_begin();
    spi_bits(8'h83, 5);
    spi_end();
    check("cfg_after_short_cmd", cfg, model_cfg());

    // Random frames
    for (int f = 0; f < 40; f++) begin
      wr  = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel < 7) addr = int'($urandom_range(0, 13));
      else if (sel == 7) addr = 127;
      else if (sel == 8) addr = 126;
      else addr = int'($urandom_range(0, 127));
      nbytes = wr ? int'($urandom_range(0, 4)) : int'($urandom_range(1, 4));
      extra  = (wr != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      for (int k = 0; k < 16; k++) tx[k] = 8'($urandom_range(0, 255));
      do_frame({wr[0], addr[6:0]}, nbytes, extra);
    end
    check("cfg_after_random", cfg, model_cfg());

    // Reset in the middle of a write burst
    frame_wr = 1'b1;
    spi_begin();
    spi_bits(8'h80, 8);
    spi_bits(8'hA5, 8);
    spi_bits(8'h5A, 8);
    #20 rst = 1'b1;
    #3;
    check_all_zero("midburst_reset");
    for (int i = 0; i < NB; i++) model_regs[i] = 8'h00;
    #50 rst = 1'b0;
    #200 nss = 1'b1;
    #300;
    check("cfg_after_abort", cfg, model_cfg());

    check("pending_commits", exp_q.size(), 0);
    check("pending_read_bytes", exp_rd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
